// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard over the shared open-drain
// PS2_CLK/PS2_DATA lines: inhibit, request-to-send, then 8 data bits,
// odd parity and stop, clocked out by the device, followed by the
// device's acknowledge bit. The device's response byte comes back through
// the separate receive path; busy tells that path to ignore the bus while
// this block owns it.
//
// Handshake: a byte is accepted on a rising clk edge where
// tx_valid && tx_ready. tx_data is sampled only on that edge. tx_valid is
// ignored while busy. Each accepted byte ends in exactly one one-cycle pulse
// on either tx_done (acknowledged) or tx_error (NACK or timeout), unless rst
// intervenes. tx_ready comes back the cycle after that pulse.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES  = 10000,
  parameter int RTS_HOLD_CYCLES = 200,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // One counter serves the inhibit, RTS-hold and timeout intervals, so it is
  // sized for the largest of them.
  localparam int CNT_MAX_A = (INHIBIT_CYCLES > RTS_HOLD_CYCLES) ? INHIBIT_CYCLES : RTS_HOLD_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  state_t           r_state;
  logic [9:0]       r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_cnt;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_tx_ready;
  logic             r_tx_done;
  logic             r_tx_error;

  logic             r_clk_s1;
  logic             r_clk_s2;
  logic             r_clk_prev;
  logic             r_dat_s1;
  logic             r_dat_s2;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_fall;
  logic             w_timeout;

  // Open-drain drive: only ever pull low or release; the bus pull-ups
  // supply the high level.
  assign PS2_CLK  = r_clk_oe  ? 1'b0 : 1'bz;
  assign PS2_DATA = r_data_oe ? 1'b0 : 1'bz;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  assign tx_ready    = r_tx_ready;
  assign busy        = (r_state != ST_IDLE);
  assign tx_done     = r_tx_done;
  assign tx_error    = r_tx_error;
  assign o_dbg_state = r_state;

  // Two-flop synchronizers for both lines, plus one extra clock stage for
  // falling-edge detection. They reset to the idle (high) bus level so no
  // false edge is seen coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= PS2_CLK;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= PS2_DATA;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // Transmit sequencer: all line drives and status pulses are registered
  // here, and reset releases both lines asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
    end else begin
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_cnt     <= '0;
          if (tx_valid && r_tx_ready) begin
            // Frame is sent LSB first: D0..D7, odd parity, stop (1).
            r_shift    <= {1'b1, ~^tx_data, tx_data};
            r_tx_ready <= 1'b0;
            r_clk_oe   <= 1'b1;
            r_state    <= ST_INHIBIT;
          end else begin
            // Held low for the pulse cycle, so ready reappears one cycle
            // after tx_done/tx_error.
            r_tx_ready <= 1'b1;
          end
        end

        ST_INHIBIT: begin
          if (w_cnt_inc == CNT_W'(INHIBIT_CYCLES)) begin
            r_cnt     <= '0;
            r_data_oe <= 1'b1;      // start bit
            r_state   <= ST_RTS;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_RTS: begin
          if (w_cnt_inc == CNT_W'(RTS_HOLD_CYCLES)) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_clk_oe  <= 1'b0;      // hand the clock to the device
            r_state   <= ST_SHIFT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_SHIFT: begin
          if (w_fall) begin
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b0, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_cnt     <= '0;
            if (r_bit_cnt == 4'd9) begin
              r_state <= ST_ACK;    // stop bit just presented (released)
            end
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_error <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_ACK: begin
          r_data_oe <= 1'b0;
          if (w_fall) begin
            r_cnt <= '0;
            if (!r_dat_s2) begin
              r_state <= ST_WAIT_IDLE;
            end else begin
              r_tx_error <= 1'b1;   // device did not pull data low: NACK
              r_state    <= ST_IDLE;
            end
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_tx_error <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_WAIT_IDLE: begin
          r_data_oe <= 1'b0;
          if (r_clk_s2 && r_dat_s2) begin
            r_tx_done <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_tx_error <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model clocks the frame out and
// acknowledges (or not); outcome pulses are checked against a queue of
// expected results filled by the stimulus side.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int RTSH = 10;
  localparam int TMO  = 500;
  localparam int HALF = 20;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  wire        tx_ready;
  wire        busy;
  wire        tx_done;
  wire        tx_error;
  wire  [2:0] dbg_state;
  wire        ps2_clk;
  wire        ps2_data;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;

  pullup(ps2_clk);
  pullup(ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_HOLD_CYCLES(RTSH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PS2_CLK    (ps2_clk),
    .PS2_DATA   (ps2_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .o_dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks  = 0;
  int          n_fail    = 0;
  logic [1:0]  exp_q[$];       // {tx_error, tx_done} expected per byte
  logic [10:0] frame_q[$];     // frame the device should capture
  int          n_done    = 0;
  int          n_err     = 0;
  int          t_done    = 0;
  int          t_err     = 0;
  int          t_release = 0;
  int          t_accept  = 0;
  bit          ready_chk = 1'b0;
  logic [1:0]  mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ready_chk) begin
      check("ready_after_pulse", {30'd0, tx_ready, busy}, 32'h2);
      ready_chk = 1'b0;
    end
    if (!rst && (tx_done || tx_error)) begin
      if (tx_done) begin n_done++; t_done = cyc; end
      if (tx_error) begin n_err++; t_err = cyc; end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b with nothing outstanding", tx_done, tx_error);
      end else begin
        mon_exp = exp_q.pop_front();
        check("outcome", {30'd0, tx_error, tx_done}, {30'd0, mon_exp});
      end
      ready_chk = 1'b1;
    end
  end

  // ---------------- driver ----------------
  // Called on a negedge. outcome 2'b01 = done, 2'b10 = error, 2'b00 = none.
  task automatic send(input logic [7:0] d, input logic par, input logic [1:0] outcome,
                      input bit push_frame, input bit hold_valid);
    int g;
    if (push_frame) frame_q.push_back({1'b1, par, d, 1'b0});
    if (outcome != 2'b00) exp_q.push_back(outcome);
    tx_data  = d;
    tx_valid = 1'b1;
    g = 0;
    while (tx_ready !== 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: byte 0x%0h never accepted", d);
    end else begin
      @(negedge clk);
      t_accept = cyc;
    end
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  // ---------------- device model ----------------
  // abort_after > 0 stops after that many falls with the clock released.
  task automatic device_xfer(input bit do_clock, input bit do_ack, input int abort_after);
    int          g;
    int          lowc;
    logic        last_dat;
    logic [10:0] got;
    logic [10:0] exp_f;
    g = 0;
    while (ps2_clk !== 1'b0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL inhibit_start: host never pulled PS2_CLK low");
      return;
    end
    lowc     = 0;
    last_dat = 1'b1;
    while (ps2_clk === 1'b0 && lowc < 2000) begin
      last_dat = ps2_data;
      lowc++;
      @(negedge clk);
    end
    t_release = cyc;
    check("inhibit_len_ge_100", {31'd0, (lowc >= INH)}, 32'd1);
    check("data_low_before_clk_release", {31'd0, last_dat}, 32'd0);
    check("busy_during_xfer", {31'd0, busy}, 32'd1);
    if (!do_clock) return;
    got    = '0;
    got[0] = ps2_data;
    for (int i = 1; i <= 10; i++) begin
      wait_cycles(HALF);
      dev_clk_low = 1'b1;
      wait_cycles(HALF);
      dev_clk_low = 1'b0;
      wait_cycles(1);
      got[i] = ps2_data;
      if (i == abort_after) return;
    end
    if (frame_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame: captured 0x%0h with no expected frame", got);
    end else begin
      exp_f = frame_q.pop_front();
      check("frame", {21'd0, got}, {21'd0, exp_f});
    end
    wait_cycles(HALF - 1);
    if (do_ack) dev_data_low = 1'b1;
    wait_cycles(5);
    dev_clk_low = 1'b1;
    wait_cycles(HALF);
    dev_clk_low = 1'b0;
    wait_cycles(2);
    dev_data_low = 1'b0;
    wait_cycles(1);
    check("lines_released_after_ack", {30'd0, ps2_clk, ps2_data}, 32'h3);
  endtask

  task automatic wait_outcomes();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL outcome_timeout: %0d outcomes still outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  int d0;
  int e0;

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_cycles(3);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
    check("reset_lines", {30'd0, ps2_clk, ps2_data}, 32'h3);
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    wait_cycles(2);

    // 0xED acknowledged: start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1
    fork
      send(8'hED, 1'b1, 2'b01, 1'b1, 1'b0);
      device_xfer(1'b1, 1'b1, 0);
    join
    wait_outcomes();
    wait_cycles(2);
    check("busy_after_idle", {31'd0, busy}, 32'd0);

    // 0x01 (parity 0) then 0xFF (parity 1) with tx_valid held high
    d0 = n_done;
    fork
      begin
        send(8'h01, 1'b0, 2'b01, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 2'b01, 1'b1, 1'b0);
        check("second_accept_after_done", {31'd0, (t_accept > t_done)}, 32'd1);
      end
      begin
        device_xfer(1'b1, 1'b1, 0);
        device_xfer(1'b1, 1'b1, 0);
      end
    join
    wait_outcomes();
    wait_cycles(2);
    check("two_done_pulses", n_done - d0, 32'd2);

    // 0xF4 (parity 0) NACKed
    d0 = n_done;
    e0 = n_err;
    fork
      send(8'hF4, 1'b0, 2'b10, 1'b1, 1'b0);
      device_xfer(1'b1, 1'b0, 0);
    join
    wait_outcomes();
    wait_cycles(2);
    check("nack_error_count", n_err - e0, 32'd1);
    check("nack_no_done", n_done - d0, 32'd0);

    // 0xFF, device never clocks: timeout 500 cycles after clock release
    fork
      send(8'hFF, 1'b1, 2'b10, 1'b0, 1'b0);
      device_xfer(1'b0, 1'b0, 0);
    join
    wait_outcomes();
    wait_cycles(2);
    check("timeout_latency", t_err - t_release, TMO);
    check("timeout_lines", {30'd0, ps2_clk, ps2_data}, 32'h3);
    check("timeout_ready", {31'd0, tx_ready}, 32'd1);

    // 0xED with reset after the 4th fall
    d0 = n_done;
    e0 = n_err;
    fork
      send(8'hED, 1'b1, 2'b00, 1'b0, 1'b0);
      device_xfer(1'b1, 1'b1, 4);
    join
    rst = 1'b1;
    #1;
    check("rst_shift_lines", {30'd0, ps2_clk, ps2_data}, 32'h3);
    check("rst_shift_ready", {31'd0, tx_ready}, 32'd1);
    wait_cycles(2);
    rst = 1'b0;

    // reset while the host is inhibiting: PS2_CLK must release at once
    wait_cycles(2);
    send(8'h55, 1'b1, 2'b00, 1'b0, 1'b0);
    wait_cycles(30);
    check("inhibit_clk_driven", {31'd0, ps2_clk}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_inhibit_clk_released", {31'd0, ps2_clk}, 32'd1);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(5);
    check("rst_no_pulses", (n_done - d0) + (n_err - e0), 32'd0);
    check("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    // 0x55 (parity 1) completes after reset
    fork
      send(8'h55, 1'b1, 2'b01, 1'b1, 1'b0);
      device_xfer(1'b1, 1'b1, 0);
    join
    wait_outcomes();
    wait_cycles(3);
    check("frames_all_consumed", frame_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
